// File: rtl/core_pkg.sv
// Shared constants and types for the MEM pipeline stage.
// Also holds the RV32I access-size decode used by the lane alignment logic.
package core_pkg;

    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;

    localparam logic [2:0]  F3_B  = 3'b000;
    localparam logic [2:0]  F3_H  = 3'b001;
    localparam logic [2:0]  F3_W  = 3'b010;
    localparam logic [2:0]  F3_BU = 3'b100;
    localparam logic [2:0]  F3_HU = 3'b101;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_t;

    // Unsigned funct3 codes only exist for loads; a store with those codes is a word access.
    function automatic acc_size_t access_size(input logic is_store, input logic [2:0] funct3);
        acc_size_t size_v;
        case (funct3)
            F3_B:    size_v = SZ_B;
            F3_H:    size_v = SZ_H;
            F3_BU:   size_v = is_store ? SZ_W : SZ_B;
            F3_HU:   size_v = is_store ? SZ_W : SZ_H;
            default: size_v = SZ_W;
        endcase
        return size_v;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store byte enables and lane data,
// load extraction with sign/zero extension, and misalignment detection.
module mem_align
    import core_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               is_store,
    input  logic [2:0]         funct3,
    input  logic [1:0]         off,
    input  logic [BITSIZE-1:0] rs2,
    input  logic [BITSIZE-1:0] rdata,
    output logic [3:0]         be,
    output logic [BITSIZE-1:0] wdata,
    output logic [BITSIZE-1:0] ldata,
    output logic               misaligned
);

    acc_size_t   size_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store lanes and alignment check, selected by access size.
    always_comb begin
        size_s     = access_size(is_store, funct3);
        be         = 4'b0000;
        wdata      = rs2;
        misaligned = 1'b0;
        case (size_s)
            SZ_B: begin
                be         = 4'b0001 << off;
                wdata      = {4{rs2[7:0]}};
                misaligned = 1'b0;
            end
            SZ_H: begin
                be         = 4'b0011 << off;
                wdata      = {2{rs2[15:0]}};
                misaligned = off[0];
            end
            default: begin
                be         = 4'b1111;
                wdata      = rs2;
                misaligned = (off != 2'b00);
            end
        endcase
    end

    // Load extraction; unknown funct3 codes return the full word.
    always_comb begin
        byte_s = rdata[{off, 3'b000} +: 8];
        half_s = rdata[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    ldata = {{24{byte_s[7]}}, byte_s};
            F3_BU:   ldata = {24'h000000, byte_s};
            F3_H:    ldata = {{16{half_s[15]}}, half_s};
            F3_HU:   ldata = {16'h0000, half_s};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: accepts EX entries, performs RV32I loads/stores on a
// single-port data memory, and hands instruction plus result to WB.
module mem_stage
    import core_pkg::*;
#(
    parameter int          BITSIZE   = 32,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               EX_MEM_give_i,
    output logic               MEM_EX_get_o,
    input  logic [31:0]        EX_MEM_instruction_i,
    input  logic [BITSIZE-1:0] EX_MEM_d_i,
    input  logic [BITSIZE-1:0] EX_MEM_rs2_i,
    output logic               MEM_WB_give_o,
    input  logic               WB_MEM_get_i,
    output logic [31:0]        MEM_WB_instruction_o,
    output logic [BITSIZE-1:0] MEM_WB_d_o,
    output logic [BITSIZE-1:0] DMEM_addr_o,
    output logic [BITSIZE-1:0] DMEM_data_o,
    output logic [3:0]         DMEM_be_o,
    output logic               DMEM_read_o,
    output logic               DMEM_write_o,
    input  logic [BITSIZE-1:0] DMEM_data_i,
    input  logic               DMEM_valid_i,
    output logic               misaligned_o
);

    mem_state_t         state_r, state_nxt_s;
    logic [31:0]        instr_r, instr_nxt_s;
    logic [BITSIZE-1:0] d_r, d_nxt_s;
    logic [BITSIZE-1:0] wdata_r, wdata_nxt_s;
    logic [3:0]         be_r, be_nxt_s;
    logic               read_r, read_nxt_s;
    logic               write_r, write_nxt_s;
    logic               mis_r, mis_nxt_s;

    logic               get_s;
    logic               accept_s;
    logic               in_load_s;
    logic               in_store_s;

    logic               al_store_s;
    logic [2:0]         al_funct3_s;
    logic [1:0]         al_off_s;
    logic [3:0]         al_be_s;
    logic [BITSIZE-1:0] al_wdata_s;
    logic [BITSIZE-1:0] al_ldata_s;
    logic               al_mis_s;

    assign in_load_s  = (EX_MEM_instruction_i[6:0] == OPC_LOAD);
    assign in_store_s = (EX_MEM_instruction_i[6:0] == OPC_STORE);
    assign get_s      = (state_r == IDLE) || ((state_r == HOLD) && WB_MEM_get_i);
    assign accept_s   = get_s && EX_MEM_give_i;

    // One aligner serves both phases: incoming entry while accepting, latched entry during ACCESS.
    always_comb begin
        if (state_r == ACCESS) begin
            al_store_s  = write_r;
            al_funct3_s = instr_r[14:12];
            al_off_s    = d_r[1:0];
        end else begin
            al_store_s  = in_store_s;
            al_funct3_s = EX_MEM_instruction_i[14:12];
            al_off_s    = EX_MEM_d_i[1:0];
        end
    end

    mem_align #(.BITSIZE(BITSIZE)) u_align (
        .is_store   (al_store_s),
        .funct3     (al_funct3_s),
        .off        (al_off_s),
        .rs2        (EX_MEM_rs2_i),
        .rdata      (DMEM_data_i),
        .be         (al_be_s),
        .wdata      (al_wdata_s),
        .ldata      (al_ldata_s),
        .misaligned (al_mis_s)
    );

    // Next-state and next-register values; an accepted entry overrides the current-state update.
    always_comb begin
        state_nxt_s = state_r;
        instr_nxt_s = instr_r;
        d_nxt_s     = d_r;
        wdata_nxt_s = wdata_r;
        be_nxt_s    = be_r;
        read_nxt_s  = read_r;
        write_nxt_s = write_r;
        mis_nxt_s   = 1'b0;

        case (state_r)
            IDLE: begin
                state_nxt_s = IDLE;
            end
            ACCESS: begin
                if (DMEM_valid_i) begin
                    state_nxt_s = HOLD;
                    d_nxt_s     = write_r ? '0 : al_ldata_s;
                    wdata_nxt_s = '0;
                    be_nxt_s    = 4'b0000;
                    read_nxt_s  = 1'b0;
                    write_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            HOLD: begin
                if (WB_MEM_get_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (accept_s) begin
            instr_nxt_s = EX_MEM_instruction_i;
            d_nxt_s     = EX_MEM_d_i;
            if ((in_load_s || in_store_s) && al_mis_s) begin
                state_nxt_s = HOLD;
                instr_nxt_s = NOP_INSTR;
                d_nxt_s     = '0;
                mis_nxt_s   = 1'b1;
            end else if (in_load_s || in_store_s) begin
                state_nxt_s = ACCESS;
                be_nxt_s    = al_be_s;
                wdata_nxt_s = in_store_s ? al_wdata_s : '0;
                read_nxt_s  = in_load_s;
                write_nxt_s = in_store_s;
            end else begin
                state_nxt_s = HOLD;
            end
        end else begin
            mis_nxt_s = 1'b0;
        end
    end

    // State and datapath registers; reset drops any in-flight request at once.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r <= IDLE;
            instr_r <= 32'h00000000;
            d_r     <= '0;
            wdata_r <= '0;
            be_r    <= 4'b0000;
            read_r  <= 1'b0;
            write_r <= 1'b0;
            mis_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            instr_r <= instr_nxt_s;
            d_r     <= d_nxt_s;
            wdata_r <= wdata_nxt_s;
            be_r    <= be_nxt_s;
            read_r  <= read_nxt_s;
            write_r <= write_nxt_s;
            mis_r   <= mis_nxt_s;
        end
    end

    assign MEM_EX_get_o         = get_s;
    assign MEM_WB_give_o        = (state_r == HOLD);
    assign MEM_WB_instruction_o = instr_r;
    assign MEM_WB_d_o           = d_r;
    assign DMEM_addr_o          = {d_r[BITSIZE-1:2], 2'b00};
    assign DMEM_data_o          = wdata_r;
    assign DMEM_be_o            = be_r;
    assign DMEM_read_o          = read_r;
    assign DMEM_write_o         = write_r;
    assign misaligned_o         = mis_r;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a byte-level memory model predicts every
// WB entry, and directed segments cover latency, lanes, stalls and reset.
module tb_mem_stage;

    logic        clk;
    logic        resetn_i;
    logic        EX_MEM_give_i;
    logic        MEM_EX_get_o;
    logic [31:0] EX_MEM_instruction_i;
    logic [31:0] EX_MEM_d_i;
    logic [31:0] EX_MEM_rs2_i;
    logic        MEM_WB_give_o;
    logic        WB_MEM_get_i;
    logic [31:0] MEM_WB_instruction_o;
    logic [31:0] MEM_WB_d_o;
    logic [31:0] DMEM_addr_o;
    logic [31:0] DMEM_data_o;
    logic [3:0]  DMEM_be_o;
    logic        DMEM_read_o;
    logic        DMEM_write_o;
    logic [31:0] DMEM_data_i;
    logic        DMEM_valid_i;
    logic        misaligned_o;

    mem_stage dut (
        .clk                  (clk),
        .resetn_i             (resetn_i),
        .EX_MEM_give_i        (EX_MEM_give_i),
        .MEM_EX_get_o         (MEM_EX_get_o),
        .EX_MEM_instruction_i (EX_MEM_instruction_i),
        .EX_MEM_d_i           (EX_MEM_d_i),
        .EX_MEM_rs2_i         (EX_MEM_rs2_i),
        .MEM_WB_give_o        (MEM_WB_give_o),
        .WB_MEM_get_i         (WB_MEM_get_i),
        .MEM_WB_instruction_o (MEM_WB_instruction_o),
        .MEM_WB_d_o           (MEM_WB_d_o),
        .DMEM_addr_o          (DMEM_addr_o),
        .DMEM_data_o          (DMEM_data_o),
        .DMEM_be_o            (DMEM_be_o),
        .DMEM_read_o          (DMEM_read_o),
        .DMEM_write_o         (DMEM_write_o),
        .DMEM_data_i          (DMEM_data_i),
        .DMEM_valid_i         (DMEM_valid_i),
        .misaligned_o         (misaligned_o)
    );

    localparam logic [31:0] INS_ADD = 32'h002081B3;
    localparam logic [31:0] INS_LB  = 32'h00008083;
    localparam logic [31:0] INS_LW  = 32'h0000A083;
    localparam logic [31:0] INS_SH  = 32'h00209023;

    int total = 0;
    int bad   = 0;

    logic [31:0] dmem [0:255];
    logic [7:0]  ref_mem [0:1023];
    logic [63:0] exp_q [$];
    int          mis_seen   = 0;
    int          mis_expect = 0;
    int          forced_waits = -1;
    bit          wb_hold = 1'b0;
    bit          wb_rand = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what WB must receive for one accepted entry, from RV32I load/store rules.
    function automatic logic [63:0] ref_model(input logic [31:0] ins, input logic [31:0] a,
                                              input logic [31:0] rs2);
        logic [6:0]  opc;
        logic [2:0]  f3;
        int          n;
        logic [31:0] v;
        opc = ins[6:0];
        f3  = ins[14:12];
        if (opc != 7'h03 && opc != 7'h23) return {ins, a};
        if (opc == 7'h23) n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        if ((a % n) != 0) begin
            mis_expect++;
            return {32'h00000013, 32'h00000000};
        end
        if (opc == 7'h23) begin
            for (int i = 0; i < n; i++) ref_mem[(a + i) & 1023] = rs2[8*i +: 8];
            return {ins, 32'h00000000};
        end
        v = 32'h00000000;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) & 1023]) << (8 * i));
        if (n == 1 && f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (n == 2 && f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        return {ins, v};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        dmem[a[9:2]] = w;
        for (int i = 0; i < 4; i++) ref_mem[{a[9:2], 2'b00} + i] = w[8*i +: 8];
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one step after a rising edge; returns one step after the transfer edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] d, input logic [31:0] rs2);
        int n;
        n = 0;
        EX_MEM_give_i        = 1'b1;
        EX_MEM_instruction_i = ins;
        EX_MEM_d_i           = d;
        EX_MEM_rs2_i         = rs2;
        @(negedge clk);
        while (!MEM_EX_get_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_accepted", MEM_EX_get_o, 1'b1);
        @(posedge clk);
        #1;
        EX_MEM_give_i = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory and WB responder, driven two steps after each rising edge.
    initial begin
        bit busy;
        int waits;
        busy = 1'b0;
        waits = 0;
        DMEM_valid_i = 1'b0;
        DMEM_data_i  = 32'h00000000;
        WB_MEM_get_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            WB_MEM_get_i = wb_hold ? 1'b0 : (wb_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            if (DMEM_read_o || DMEM_write_o) begin
                if (!busy) begin
                    busy  = 1'b1;
                    waits = (forced_waits >= 0) ? forced_waits : int'($urandom_range(0, 3));
                end
                if (waits == 0) begin
                    DMEM_valid_i = 1'b1;
                    DMEM_data_i  = dmem[DMEM_addr_o[9:2]];
                    if (DMEM_write_o)
                        for (int b = 0; b < 4; b++)
                            if (DMEM_be_o[b]) dmem[DMEM_addr_o[9:2]][8*b +: 8] = DMEM_data_o[8*b +: 8];
                    busy = 1'b0;
                end else begin
                    DMEM_valid_i = 1'b0;
                    waits--;
                end
            end else begin
                DMEM_valid_i = 1'b0;
                busy = 1'b0;
            end
        end
    end

    // Scoreboard: handshakes are decided by values stable at the falling edge.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!resetn_i) begin
                exp_q.delete();
            end else begin
                check_eq("rd_wr_exclusive", DMEM_read_o & DMEM_write_o, 1'b0);
                if (DMEM_read_o || DMEM_write_o) check_eq("addr_word_aligned", DMEM_addr_o[1:0], 2'b00);
                if (misaligned_o) mis_seen++;
                if (MEM_WB_give_o && WB_MEM_get_i) begin
                    check_eq("wb_has_entry", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("wb_instr", MEM_WB_instruction_o, e[63:32]);
                        check_eq("wb_data", MEM_WB_d_o, e[31:0]);
                    end
                end
                if (EX_MEM_give_i && MEM_EX_get_o)
                    exp_q.push_back(ref_model(EX_MEM_instruction_i, EX_MEM_d_i, EX_MEM_rs2_i));
            end
        end
    end

    initial begin
        int n_acc;
        logic [31:0] ins;
        logic [31:0] addr;
        logic [6:0]  opcs [5];
        opcs = '{7'h33, 7'h13, 7'h37, 7'h63, 7'h6F};
        resetn_i             = 1'b0;
        EX_MEM_give_i        = 1'b0;
        EX_MEM_instruction_i = 32'h00000000;
        EX_MEM_d_i           = 32'h00000000;
        EX_MEM_rs2_i         = 32'h00000000;
        for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);

        repeat (2) @(negedge clk);
        check_eq("rst_get", MEM_EX_get_o, 1'b1);
        check_eq("rst_give", MEM_WB_give_o, 1'b0);
        check_eq("rst_read", DMEM_read_o, 1'b0);
        check_eq("rst_write", DMEM_write_o, 1'b0);
        check_eq("rst_be", DMEM_be_o, 4'b0000);
        check_eq("rst_mis", misaligned_o, 1'b0);
        check_eq("rst_instr", MEM_WB_instruction_o, 32'h00000000);
        check_eq("rst_d", MEM_WB_d_o, 32'h00000000);
        @(posedge clk);
        #1 resetn_i = 1'b1;
        idle(1);

        // ALU result reaches WB one cycle after the transfer.
        send(INS_ADD, 32'hDEADBEEF, 32'h0);
        check_eq("add_give", MEM_WB_give_o, 1'b1);
        check_eq("add_d", MEM_WB_d_o, 32'hDEADBEEF);
        idle(2);

        // LB with two wait states.
        preload(32'h00001000, 32'h80112233);
        forced_waits = 2;
        send(INS_LB, 32'h00001003, 32'h0);
        n_acc = 0;
        for (int i = 0; i < 20 && !MEM_WB_give_o; i++) begin
            @(negedge clk);
            if (DMEM_read_o) begin
                n_acc++;
                check_eq("lb_addr", DMEM_addr_o, 32'h00001000);
            end
        end
        check_eq("lb_read_cycles", n_acc, 3);
        check_eq("lb_d", MEM_WB_d_o, 32'hFFFFFF80);
        idle(2);

        // SH at offset 2 with one wait state.
        forced_waits = 1;
        send(INS_SH, 32'h00002002, 32'h0000ABCD);
        check_eq("sh_be", DMEM_be_o, 4'b1100);
        check_eq("sh_data", DMEM_data_o, 32'hABCDABCD);
        check_eq("sh_addr", DMEM_addr_o, 32'h00002000);
        check_eq("sh_no_read", DMEM_read_o, 1'b0);
        n_acc = 0;
        for (int i = 0; i < 20 && !MEM_WB_give_o; i++) begin
            @(negedge clk);
            if (DMEM_write_o) n_acc++;
        end
        check_eq("sh_write_cycles", n_acc, 2);
        check_eq("sh_wb_instr", MEM_WB_instruction_o, INS_SH);
        check_eq("sh_wb_d", MEM_WB_d_o, 32'h00000000);
        forced_waits = -1;
        idle(2);

        // Misaligned LW becomes a NOP without touching memory.
        send(INS_LW, 32'h00001001, 32'h0);
        check_eq("mis_pulse", misaligned_o, 1'b1);
        check_eq("mis_no_read", DMEM_read_o, 1'b0);
        check_eq("mis_instr", MEM_WB_instruction_o, 32'h00000013);
        check_eq("mis_d", MEM_WB_d_o, 32'h00000000);
        idle(1);
        check_eq("mis_pulse_end", misaligned_o, 1'b0);
        idle(2);

        // WB stalls for three cycles with a second entry waiting.
        wb_hold = 1'b1;
        idle(1);
        send(INS_ADD, 32'h11111111, 32'h0);
        fork
            send(INS_ADD | 32'h00000F00, 32'h22222222, 32'h0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("stall_get", MEM_EX_get_o, 1'b0);
                    check_eq("stall_give", MEM_WB_give_o, 1'b1);
                    check_eq("stall_d", MEM_WB_d_o, 32'h11111111);
                    check_eq("stall_instr", MEM_WB_instruction_o, INS_ADD);
                end
                wb_hold = 1'b0;
            end
        join
        idle(4);
        check_eq("stall_drained", exp_q.size(), 0);

        // Reset during a long load access.
        forced_waits = 10;
        send(INS_LW, 32'h00001004, 32'h0);
        check_eq("rstacc_read_before", DMEM_read_o, 1'b1);
        #3 resetn_i = 1'b0;
        #1;
        check_eq("rstacc_read_drop", DMEM_read_o, 1'b0);
        check_eq("rstacc_give", MEM_WB_give_o, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1 resetn_i = 1'b1;
        forced_waits = -1;
        @(negedge clk);
        check_eq("rstacc_get_idle", MEM_EX_get_o, 1'b1);
        check_eq("rstacc_give_idle", MEM_WB_give_o, 1'b0);
        idle(1);

        // Randomized mix of ALU, load and store entries.
        wb_rand = 1'b1;
        for (int t = 0; t < 300; t++) begin
            addr = $urandom_range(0, 1023);
            case ($urandom_range(0, 2))
                0:       ins = {$urandom_range(0, 33554431), 7'h00} | 32'(opcs[$urandom_range(0, 4)]);
                1:       ins = {17'($urandom), 3'($urandom_range(0, 7)), 5'($urandom), 7'h03};
                default: ins = {17'($urandom), 3'($urandom_range(0, 7)), 5'($urandom), 7'h23};
            endcase
            send(ins, addr, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        wb_rand = 1'b0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
        check_eq("final_drained", exp_q.size(), 0);
        check_eq("misaligned_count", mis_seen, mis_expect);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
